ws2812_frame_scheduler: RTL and testbench

Frame-level sequencer for the WS2812 bit transmitter. It reads a frame of 24-bit pixels from a single-port pixel RAM and hands them word-by-word to the transmitter over the tx_en/tx_rgb/tx_done handshake. After the last pixel it enforces the WS2812 latch/reset gap. It supports one-shot start and continuous auto-refresh, and sits between the pixel buffer and the bit-level transmitter.

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_brightness_scale.sv | 20 ++
 rtl/ws2812_frame_scheduler.sv | 145 ++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame path.
package ws2812_pkg;

  localparam int PIXEL_W              = 24;
  localparam int CLK_HZ               = 50_000_000;
  localparam int DEFAULT_RESET_CYCLES = 15000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SEND,
    GAP
  } state_t;

endpackage

// File: rtl/ws2812_brightness_scale.sv
// Combinational per-channel brightness scaler: c' = (c * (level + 1)) >> 8.
// Only instantiated when WS2812_BRIGHTNESS_EN is defined.
module ws2812_brightness_scale
  import ws2812_pkg::*;
(
  input  logic [PIXEL_W-1:0] pixel,
  input  logic [7:0]         level,
  output logic [PIXEL_W-1:0] scaled
);

  logic [8:0] gain;

  assign gain = {1'b0, level} + 9'd1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    // 8-bit channel times a 9-bit gain of at most 256 fits in 16 bits.
    assign scaled[gi*8 +: 8] = 8'(({8'd0, pixel[gi*8 +: 8]} * {7'd0, gain}) >> 8);
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame sequencer: fetches pixels from RAM, feeds the WS2812 transmitter, enforces latch gap.
// Optional brightness scaling of each word at LOAD when WS2812_BRIGHTNESS_EN is defined.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int MAX_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int GAP_W        = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]           brightness,
`endif
  input  logic                 start,
  input  logic                 auto_refresh,
  input  logic [ADDR_W:0]      num_leds,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [PIXEL_W-1:0]   rd_data,
  output logic                 tx_en,
  output logic [PIXEL_W-1:0]   tx_rgb,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [ADDR_W:0]  MAX_CNT  = (ADDR_W+1)'(MAX_LEDS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pending;

  logic [ADDR_W:0]    start_cnt;
  logic               last_word;
  logic [PIXEL_W-1:0] pixel;

  assign start_cnt = (num_leds > MAX_CNT) ? MAX_CNT : num_leds;
  assign last_word = ({1'b0, idx} + (ADDR_W+1)'(1)) == count;

`ifdef WS2812_BRIGHTNESS_EN
  ws2812_brightness_scale u_scale (
    .pixel  (rd_data),
    .level  (brightness),
    .scaled (pixel)
  );
`else
  assign pixel = rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      pending    <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tx_en      <= 1'b0;
      tx_rgb     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      frame_done <= 1'b0;
      if (start && busy)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start || auto_refresh) begin
            count   <= start_cnt;
            idx     <= '0;
            gap_cnt <= '0;
            busy    <= 1'b1;
            if (start_cnt != '0) begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
              state   <= READ;
            end else begin
              state <= GAP;
            end
          end
        end

        READ: state <= LOAD;

        LOAD: begin
          tx_rgb <= pixel;
          tx_en  <= 1'b1;
          state  <= SEND;
        end

        SEND: begin
          if (tx_done) begin
            if (last_word) begin
              tx_en   <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              idx     <= idx + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= idx + 1'b1;
              state   <= READ;
            end
          end
        end

        GAP: begin
          tx_en <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            frame_done <= 1'b1;
            // A start landing on the final gap cycle is folded into this restart.
            if (pending || start || auto_refresh) begin
              pending <= 1'b0;
              count   <= start_cnt;
              idx     <= '0;
              gap_cnt <= '0;
              if (start_cnt != '0) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
                state   <= READ;
              end else begin
                state <= GAP;
              end
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler with a pixel RAM and transmitter model.
module tb_ws2812_frame_scheduler;

  localparam int MAX_LEDS = 64;
  localparam int ADDR_W   = 6;
  localparam int GAP      = 1000;  // shortened latch gap keeps the run short

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              auto_refresh;
  logic [ADDR_W:0]   num_leds;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              tx_en;
  logic [23:0]       tx_rgb;
  logic              tx_done;
  logic              busy;
  logic              frame_done;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]        brightness;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ws2812_frame_scheduler #(
    .MAX_LEDS     (MAX_LEDS),
    .ADDR_W       (ADDR_W),
    .RESET_CYCLES (GAP),
    .GAP_W        (14)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness   (brightness),
`endif
    .start        (start),
    .auto_refresh (auto_refresh),
    .num_leds     (num_leds),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .tx_en        (tx_en),
    .tx_rgb       (tx_rgb),
    .tx_done      (tx_done),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pixel RAM with one-cycle registered read.
  logic [23:0] ram [MAX_LEDS];
  always @(posedge clk)
    if (rd_en === 1'b1)
      rd_data <= ram[rd_addr];

  // Monitor and transmitter model, both sampled on the falling edge.
  int   cyc = 0;
  int   fd_count = 0;
  int   rise_count = 0;
  int   fall_cyc = 0;
  int   fd_cyc = 0;
  int   low_len = 0;
  int   busy_rise_cyc = 0;
  int   tick = 0;
  int   period = 60;
  logic busy_at_fd = 1'b0;
  logic busy_before_fd = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_tx_en = 1'b0;
  logic [ADDR_W-1:0] addr_q [$];
  logic [23:0]       word_q [$];

  always @(negedge clk) begin
    cyc++;
    if (rd_en === 1'b1)
      addr_q.push_back(rd_addr);
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc         = cyc;
      busy_at_fd     = busy;
      busy_before_fd = prev_busy;
    end
    if (prev_tx_en && tx_en !== 1'b1)
      fall_cyc = cyc;
    if (!prev_tx_en && tx_en === 1'b1) begin
      rise_count++;
      low_len = cyc - fall_cyc;
    end
    if (!prev_busy && busy === 1'b1)
      busy_rise_cyc = cyc;
    prev_tx_en = (tx_en === 1'b1);
    prev_busy  = (busy === 1'b1);
    if (tx_en !== 1'b1) begin
      tick    = 0;
      tx_done = 1'b0;
    end else begin
      tick++;
      if (tick == period) begin
        tick    = 0;
        tx_done = 1'b1;
        word_q.push_back(tx_rgb);
      end else begin
        tx_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int bound, input string tag);
    int k = 0;
    while (fd_count < target && k < bound) begin
      tick_n(1);
      k++;
    end
    check(tag, fd_count, target);
  endtask

  task automatic wait_words(input int target, input int bound, input string tag);
    int k = 0;
    while (word_q.size() < target && k < bound) begin
      tick_n(1);
      k++;
    end
    check(tag, word_q.size(), target);
  endtask

  int base_fd, base_addr, base_word, base_rise;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    auto_refresh = 1'b0;
    num_leds     = '0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness   = 8'd255;
`endif
    for (int i = 0; i < MAX_LEDS; i++)
      ram[i] = 24'(i * 24'h010307) ^ 24'h5A3C96;
    ram[0] = 24'hFF00FF;
    ram[1] = 24'h00FF00;
    ram[2] = 24'hAA55AA;
    ram[3] = 24'hA543D5;

    // Reset state
    tick_n(3);
    check("rst tx_en", tx_en, 0);
    check("rst busy", busy, 0);
    check("rst rd_en", rd_en, 0);
    check("rst frame_done", frame_done, 0);
    check("rst tx_rgb", tx_rgb, 0);
    check("rst rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    tick_n(2);

    // Four-pixel one-shot frame, 1500-cycle words
    period    = 1500;
    num_leds  = 7'd4;
    base_fd   = fd_count;
    base_addr = addr_q.size();
    base_word = word_q.size();
    pulse_start();
    check("B busy after start", busy, 1);
    check("B rd_en in READ", rd_en, 1);
    check("B rd_addr first", rd_addr, 0);
    check("B tx_en not yet", tx_en, 0);
    tick_n(1);
    check("B tx_en in LOAD", tx_en, 0);
    tick_n(1);
    check("B tx_en rises", tx_en, 1);
    check("B first tx_rgb", tx_rgb, 24'hFF00FF);
    wait_fd(base_fd + 1, 4 * 1500 + GAP + 100, "B frame_done seen");
    check("B word count", word_q.size() - base_word, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("B word%0d", i), word_q[base_word + i], ram[i]);
      check($sformatf("B addr%0d", i), addr_q[base_addr + i], i);
    end
    check("B gap length", fd_cyc - fall_cyc, GAP);
    check("B busy at frame_done", busy_at_fd, 0);
    check("B busy before frame_done", busy_before_fd, 1);
    tick_n(50);
    check("B idle no reads", addr_q.size() - base_addr, 4);
    check("B idle no frame", fd_count - base_fd, 1);

    // Reset asserted while sending pixel 2
    period    = 60;
    num_leds  = 7'd4;
    base_word = word_q.size();
    pulse_start();
    wait_words(base_word + 2, 400, "F two words sent");
    tick_n(5);
    check("F tx_en before reset", tx_en, 1);
    #3 rst_n = 1'b0;
    #1;
    check("F async tx_en", tx_en, 0);
    check("F async busy", busy, 0);
    check("F async rd_en", rd_en, 0);
    base_fd = fd_count;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(GAP + 200);
    check("F no frame_done", fd_count - base_fd, 0);
    num_leds  = 7'd1;
    base_word = word_q.size();
    pulse_start();
    wait_fd(base_fd + 1, GAP + 300, "F fresh frame_done");
    check("F fresh words", word_q.size() - base_word, 1);
    check("F fresh word0", word_q[base_word], ram[0]);

    // Auto-refresh, two pixels per frame
    num_leds  = 7'd2;
    base_fd   = fd_count;
    base_addr = addr_q.size();
    base_rise = rise_count;
    auto_refresh = 1'b1;
    wait_fd(base_fd + 1, 2 * 60 + GAP + 100, "C first frame_done");
    auto_refresh = 1'b0;
    check("C busy across frames", busy, 1);
    wait_fd(base_fd + 2, 2 * 60 + GAP + 100, "C second frame_done");
    // tx_en low time = latch gap plus the READ/LOAD fetch of the next word
    check("C tx_en low length", low_len, GAP + 2);
    check("C tx_en bursts", rise_count - base_rise, 2);
    tick_n(GAP + 200);
    check("C stops after level drop", fd_count - base_fd, 2);
    check("C read count", addr_q.size() - base_addr, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("C addr%0d", i), addr_q[base_addr + i], i % 2);

    // Two starts during SEND merge into one extra frame
    base_fd   = fd_count;
    base_addr = addr_q.size();
    pulse_start();
    tick_n(10);
    pulse_start();
    tick_n(5);
    pulse_start();
    wait_fd(base_fd + 2, 2 * (2 * 60 + GAP) + 200, "D two frames");
    tick_n(GAP + 200);
    check("D exactly two frames", fd_count - base_fd, 2);
    check("D read count", addr_q.size() - base_addr, 4);
    check("D idle busy", busy, 0);

    // Zero-length frame still enforces the gap
    num_leds  = 7'd0;
    base_fd   = fd_count;
    base_addr = addr_q.size();
    base_rise = rise_count;
    pulse_start();
    check("E busy", busy, 1);
    wait_fd(base_fd + 1, GAP + 50, "E frame_done");
    check("E gap length", fd_cyc - busy_rise_cyc, GAP);
    check("E no reads", addr_q.size() - base_addr, 0);
    check("E no tx_en", rise_count - base_rise, 0);
    check("E busy at frame_done", busy_at_fd, 0);

    // Oversized frame request is clamped to MAX_LEDS
    period    = 20;
    num_leds  = 7'd100;
    base_fd   = fd_count;
    base_addr = addr_q.size();
    base_word = word_q.size();
    pulse_start();
    wait_fd(base_fd + 1, 64 * 20 + GAP + 300, "G frame_done");
    check("G word count", word_q.size() - base_word, 64);
    check("G read count", addr_q.size() - base_addr, 64);
    check("G last addr", addr_q[addr_q.size() - 1], 63);
    check("G first word", word_q[base_word], ram[0]);
    check("G last word", word_q[word_q.size() - 1], ram[63]);

`ifdef WS2812_BRIGHTNESS_EN
    // Brightness scaling at LOAD
    ram[0]     = 24'hFF8040;
    num_leds   = 7'd1;
    brightness = 8'd127;
    base_fd    = fd_count;
    base_word  = word_q.size();
    pulse_start();
    wait_fd(base_fd + 1, GAP + 100, "H dim frame_done");
    check("H dim word", word_q[base_word], 24'h7F4020);
    brightness = 8'd255;
    base_word  = word_q.size();
    pulse_start();
    wait_fd(base_fd + 2, GAP + 100, "H full frame_done");
    check("H full word", word_q[base_word], 24'hFF8040);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
